dma_mem_responder: RTL
======================

# dma_mem_responder

Memory-side responder for the matrix accelerator's DMA master port. It owns a single-port word SRAM holding matrices A, B and C, and services the accelerator's `dma_req`/`dma_ack` reads and writes with a programmable wait-state count. A Wishbone slave port lets the CPU preload operands and read back results through the same memory. The block sits between the accelerator and the system bus, in the position the bench memory model occupies today.

## Interface
- `DEPTH`, default 4096: number of 32-bit words; power of two.
- `BASE_ADDR`, default 32'h0000_1000: byte address of word 0; the window is `BASE_ADDR .. BASE_ADDR+4*DEPTH-1`.
- `WAIT_CYCLES`, default 1: wait states inserted before each ack; legal range 0..15.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `dma_req` in 1: accelerator request; held with addr/we/data until ack.
- `dma_addr` in 32: byte address.
- `dma_we` in 1: 1 = write, 0 = read.
- `dma_data_o` in 32: accelerator write data.
- `dma_data_i` out 32: read data; valid only while `dma_ack`=1.
- `dma_ack` out 1: one-cycle completion pulse.
- `wb_adr_i` in 32: CPU byte address, using the same window as DMA.
- `wb_dat_i` in 32: CPU write data.
- `wb_dat_o` out 32: CPU read data; valid only while `wb_ack_o`=1.
- `wb_we_i` in 1: CPU write enable.
- `wb_stb_i` in 1: CPU strobe.
- `wb_ack_o` out 1: one-cycle completion pulse.
- `dma_err` out 1: sticky error flag; cleared only by reset.

## Operation
- **FSM states:** IDLE, WAIT, ACK, HOLDOFF.
- **IDLE:** samples `dma_req` and `wb_stb_i`.
  - If only one is high, that source is granted.
  - If both are high, the source not granted last time wins. The `last_grant` register resets to WB, so DMA wins the first tie.
  - On a grant, the block latches address, we, write data and source, then moves to WAIT. If `WAIT_CYCLES`=0 it moves straight to ACK.
- **WAIT:** the counter counts `WAIT_CYCLES` cycles, then the FSM moves to ACK. Requester inputs are ignored here; the latched copies are used.
- **ACK:** exactly one cycle; only the granted source's ack is high.
  - Write: the memory word is updated at the end of this cycle.
  - Read: data is driven this cycle from the memory read issued at grant.
  - The FSM then moves to HOLDOFF.
- **HOLDOFF:** one cycle in which all requests are ignored, so a requester that drops its request on the cycle after ack is never double-served. The FSM then returns to IDLE.
- **Address decode:** word index = `(addr - BASE_ADDR) >> 2`, using the low `log2(DEPTH)` bits.
- **Invalid access:** an address outside the window, or with `addr[1:0]` ≠ 0, is invalid.
  - It is still acked with normal timing.
  - Read data is 32'h0 and writes are dropped.
  - On a DMA invalid access, `dma_err` is set.
  - On a WB invalid access, the same rules apply but `dma_err` is not touched.
- **Memory contents** are not initialised and are not cleared by reset.

## Timing
- **Reset values:** `dma_ack`=0, `wb_ack_o`=0, `dma_data_i`=0, `wb_dat_o`=0, `dma_err`=0, state IDLE, counter 0, `last_grant`=WB.
- **Latency:** a request sampled high in IDLE at edge t gets its ack high during cycle t+1+`WAIT_CYCLES`. With the default, a request seen at edge 0 is acked in cycle 2.
- **Throughput:** the earliest next grant is the IDLE cycle after HOLDOFF. Back-to-back transactions therefore take `WAIT_CYCLES`+3 cycles each.
- **Ack outputs** are registered; read data is registered alongside the ack and returns to 0 when the ack drops.
- **Reset mid-transaction:** the transaction is abandoned with no ack and no memory write, and the FSM goes to IDLE on the next cycle. A request still held afterwards is served as new.
- **Request dropped before ack** (a protocol violation): the transaction still completes on the latched values, and the ack is still pulsed.

## Structure
- **Shared package `dma_mem_pkg`:** the state enum (IDLE/WAIT/ACK/HOLDOFF), the grant-source encoding (SRC_DMA/SRC_WB), and the invalid-read constant 32'h0.
- **Sub-module `dma_mem_sram`:** single-port synchronous RAM, `DEPTH`×32, with one-cycle read latency and a write-enable input. The FSM, arbiter and decode stay in the top module.

## Test plan
Scenarios 1–5 use the default parameters; scenario 6 uses `WAIT_CYCLES`=0.
1. **WB preload then DMA read.** WB writes 7 to 0x2000; DMA reads 0x2000 with req sampled at edge 0. Required: `dma_ack` high in cycle 2 only, `dma_data_i`=7.
2. **DMA write then WB read.** DMA writes 158 to 0x3000; WB reads 0x3000. Required: `wb_ack_o` one cycle, `wb_dat_o`=158; `dma_err` stays 0.
3. **Simultaneous requests.** `dma_req` and `wb_stb_i` both rise together after reset, twice in a row. Required: first grant DMA, second grant WB; the two acks are never high together.
4. **Invalid DMA read.** DMA reads 0x0800, then DMA writes 5 to 0x1002. Required: both acked, read data 0, `dma_err`=1 and sticky; word 0x1000 unchanged.
5. **Reset during WAIT.** Assert `reset` for one cycle while in WAIT on a DMA write of 9 to 0x1004. Required: no `dma_ack`, and a later read of 0x1004 returns the old value.
6. **Held request and throughput.** Hold `dma_req` high continuously on reads of 0x1000. Required: acks every 3 cycles, each a distinct transaction with no extra ack inside HOLDOFF.

Source files
------------

// File: rtl/dma_mem_pkg.sv
// Shared types for the DMA memory responder.
// State encoding, grant-source encoding and the invalid-read value.
package dma_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  typedef enum logic {
    SRC_DMA = 1'b0,
    SRC_WB  = 1'b1
  } src_e;

  localparam logic [31:0] INVALID_RDATA = 32'h0;

endpackage

// File: rtl/dma_mem_sram.sv
// Single-port synchronous word RAM, one-cycle read latency.
// Ports: clk, re/we enables, word addr, wdata in, rdata out (held).
module dma_mem_sram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dma_mem_responder.sv
// Word SRAM shared by the accelerator DMA port and a Wishbone slave.
// Ports: clk/reset, dma_* request/ack, wb_* slave, sticky dma_err.
import dma_mem_pkg::*;

module dma_mem_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic        dma_we,
  input  logic [31:0] dma_data_o,
  output logic [31:0] dma_data_i,
  output logic        dma_ack,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        dma_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [29:0] BASE_W  = BASE_ADDR[31:2];
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  src_e           last_q, last_d;
  src_e           src_q, src_d;
  logic           we_q, we_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           ok_q, ok_d;
  logic           dma_ack_q, dma_ack_d;
  logic           wb_ack_q, wb_ack_d;
  logic           err_q, err_d;

  logic [29:0]    dma_woff, wb_woff;
  logic           dma_ok, wb_ok;
  logic           grant_dma, grant_wb;
  logic           ram_re, ram_we;
  logic [AW-1:0]  ram_addr;
  logic [31:0]    ram_rdata;

  // Word offset from the window base; below-base addresses are
  // rejected by the explicit compare, not by wraparound.
  assign dma_woff = dma_addr[31:2] - BASE_W;
  assign wb_woff  = wb_adr_i[31:2] - BASE_W;
  assign dma_ok   = (dma_addr[31:2] >= BASE_W) &&
                    (dma_woff < DEPTH_W) &&
                    (dma_addr[1:0] == 2'b00);
  assign wb_ok    = (wb_adr_i[31:2] >= BASE_W) &&
                    (wb_woff < DEPTH_W) &&
                    (wb_adr_i[1:0] == 2'b00);

  // On a tie the source not granted last time wins.
  assign grant_dma = dma_req && (!wb_stb_i || last_q == SRC_WB);
  assign grant_wb  = wb_stb_i && !grant_dma;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    src_d     = src_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    ok_d      = ok_q;
    err_d     = err_q;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = idx_q;
    unique case (state_q)
      IDLE: begin
        if (grant_dma || grant_wb) begin
          src_d   = grant_dma ? SRC_DMA : SRC_WB;
          last_d  = src_d;
          we_d    = grant_dma ? dma_we : wb_we_i;
          wdata_d = grant_dma ? dma_data_o : wb_dat_i;
          idx_d   = grant_dma ? dma_woff[AW-1:0]
                              : wb_woff[AW-1:0];
          ok_d    = grant_dma ? dma_ok : wb_ok;
          // Read is issued at grant so data is ready by ACK.
          ram_re   = 1'b1;
          ram_addr = idx_d;
          if (WAIT_CYCLES == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACK;
        else cnt_d = cnt_q - 4'd1;
      end
      ACK: begin
        state_d = HOLDOFF;
        ram_we  = we_q && ok_q && !reset;
      end
      HOLDOFF: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    dma_ack_d = (state_d == ACK) && (src_d == SRC_DMA);
    wb_ack_d  = (state_d == ACK) && (src_d == SRC_WB);
    if (dma_ack_d && !ok_d) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_q    <= SRC_WB;
      src_q     <= SRC_DMA;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
      idx_q     <= '0;
      ok_q      <= 1'b0;
      dma_ack_q <= 1'b0;
      wb_ack_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      src_q     <= src_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      ok_q      <= ok_d;
      dma_ack_q <= dma_ack_d;
      wb_ack_q  <= wb_ack_d;
      err_q     <= err_d;
    end
  end

  dma_mem_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // RAM output is a flop; gating it with the ack flop keeps the
  // data bus at zero outside the ack cycle and for invalid reads.
  assign dma_ack    = dma_ack_q;
  assign wb_ack_o   = wb_ack_q;
  assign dma_err    = err_q;
  assign dma_data_i = (dma_ack_q && !we_q && ok_q) ? ram_rdata
                                                   : INVALID_RDATA;
  assign wb_dat_o   = (wb_ack_q && !we_q && ok_q) ? ram_rdata
                                                  : INVALID_RDATA;

endmodule
